frame_load_ctrl: RTL and testbench

Sequences reception of one image frame from the UART receiver into the frame-buffer RAM write port. Sits between the UART RX byte stream and the frame buffer, and replies through the UART TX with an ACK/NAK byte. Each frame is a 2-byte header followed by exactly FRAME_PIXELS pixel bytes. The low 3 bits of each pixel byte are the RGB colour. Generates write address, write enable and write data, detects framing errors and inter-byte timeouts, and exposes status for LEDs and debug.

---
 rtl/frame_load_ctrl.sv | 153 +++++++++++++++
 tb/tb_frame_load_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_load_ctrl.sv
// Receives one header-prefixed pixel frame from the UART byte stream, writes it into the
// frame buffer, and queues an ACK/NAK reply byte for the UART transmitter.
module frame_load_ctrl #(
   parameter int          FRAME_PIXELS = 19200,
   parameter int          ADDR_W       = 15,
   parameter int          TIMEOUT_CYC  = 5_000_000,
   parameter logic [7:0]  HDR0         = 8'hA5,
   parameter logic [7:0]  HDR1         = 8'h5A,
   parameter logic [7:0]  ACK_OK       = 8'h06,
   parameter logic [7:0]  ACK_ERR      = 8'h15
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_frame_error,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [2:0]        wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic [7:0]        err_count,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      DATA = 3'd2,
      SEND = 3'd3
   } state_t;

   localparam int                TO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

   state_t            cur_state, nxt_state;
   logic [ADDR_W-1:0] pix_cnt, pix_cnt_nxt;
   logic [TO_W-1:0]   idle_cnt, idle_cnt_nxt;
   logic              timeout;
   logic              wr_en_nxt, tx_start_nxt, frame_done_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [2:0]        wr_data_nxt;
   logic [7:0]        tx_data_nxt, err_count_nxt;

   // The current clock is the TIMEOUT_CYC-th consecutive one without a byte
   assign timeout = !rx_valid && (idle_cnt == TO_LAST);
   assign state   = cur_state;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         cur_state  <= IDLE;
         pix_cnt    <= '0;
         idle_cnt   <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 3'd0;
         tx_start   <= 1'b0;
         tx_data    <= 8'd0;
         frame_done <= 1'b0;
         err_count  <= 8'd0;
         busy       <= 1'b0;
      end else begin
         cur_state  <= nxt_state;
         pix_cnt    <= pix_cnt_nxt;
         idle_cnt   <= idle_cnt_nxt;
         wr_en      <= wr_en_nxt;
         wr_addr    <= wr_addr_nxt;
         wr_data    <= wr_data_nxt;
         tx_start   <= tx_start_nxt;
         tx_data    <= tx_data_nxt;
         frame_done <= frame_done_nxt;
         err_count  <= err_count_nxt;
         busy       <= (nxt_state != IDLE);
      end
   end

   always_comb begin
      nxt_state      = cur_state;
      pix_cnt_nxt    = pix_cnt;
      idle_cnt_nxt   = idle_cnt;
      wr_en_nxt      = 1'b0;
      wr_addr_nxt    = wr_addr;
      wr_data_nxt    = wr_data;
      tx_start_nxt   = 1'b0;
      tx_data_nxt    = tx_data;
      frame_done_nxt = 1'b0;
      err_count_nxt  = err_count;

      case (cur_state)
         IDLE: begin
            if (rx_valid && !rx_frame_error && rx_data == HDR0) begin
               nxt_state    = HDR;
               idle_cnt_nxt = '0;
            end
         end

         HDR: begin
            idle_cnt_nxt = idle_cnt + 1'b1;
            if (rx_frame_error) begin
               nxt_state = IDLE;
            end else if (rx_valid) begin
               idle_cnt_nxt = '0;
               if (rx_data == HDR1) begin
                  nxt_state   = DATA;
                  pix_cnt_nxt = '0;
               end else if (rx_data != HDR0) begin
                  nxt_state = IDLE;
               end
            end else if (timeout) begin
               nxt_state = IDLE;
            end
         end

         DATA: begin
            idle_cnt_nxt = idle_cnt + 1'b1;
            // A framing error beats a byte arriving in the same cycle
            if (rx_frame_error || (!rx_valid && timeout)) begin
               tx_data_nxt = ACK_ERR;
               if (err_count != 8'hFF) begin
                  err_count_nxt = err_count + 8'd1;
               end
               nxt_state = SEND;
            end else if (rx_valid) begin
               idle_cnt_nxt = '0;
               wr_en_nxt    = 1'b1;
               wr_addr_nxt  = pix_cnt;
               wr_data_nxt  = rx_data[2:0];
               if (pix_cnt == LAST_PIX) begin
                  frame_done_nxt = 1'b1;
                  tx_data_nxt    = ACK_OK;
                  nxt_state      = SEND;
               end else begin
                  pix_cnt_nxt = pix_cnt + 1'b1;
               end
            end
         end

         SEND: begin
            if (!tx_busy) begin
               tx_start_nxt = 1'b1;
               nxt_state    = IDLE;
            end
         end

         default: nxt_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Scoreboard bench for frame_load_ctrl: stimulus pushes expected writes and reply bytes,
// a negedge monitor pops and compares them whenever the DUT presents wr_en or tx_start.
module tb_frame_load_ctrl;

   localparam int FP  = 8;
   localparam int AW  = 15;
   localparam int TO  = 1000;
   localparam int GAP = 20;

   typedef struct {
      logic [AW-1:0] addr;
      logic [2:0]    data;
      logic          done;
   } wr_t;

   logic          CLOCK_50 = 1'b0;
   logic          rst_n;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_frame_error = 1'b0;
   logic          tx_busy = 1'b0;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [2:0]    wr_data;
   logic          busy;
   logic          frame_done;
   logic [7:0]    err_count;
   logic [2:0]    state;

   wr_t        wr_q[$];
   logic [7:0] tx_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_wr_cyc = 0;
   int         tx_cyc = 0;
   int         drop_cyc = 0;

   frame_load_ctrl #(
      .FRAME_PIXELS(FP),
      .ADDR_W(AW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .rst_n(rst_n),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .rx_frame_error(rx_frame_error),
      .tx_busy(tx_busy),
      .tx_start(tx_start),
      .tx_data(tx_data),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .busy(busy),
      .frame_done(frame_done),
      .err_count(err_count),
      .state(state)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pushWrite(input int addr, input int data, input logic done);
      wr_t w;
      w.addr = AW'(addr);
      w.data = 3'(data);
      w.done = done;
      wr_q.push_back(w);
   endtask

   // One received byte: a single-cycle rx_valid pulse followed by an inter-byte gap
   task automatic applyStimulus(input logic [7:0] b, input logic err);
      @(posedge CLOCK_50);
      #1;
      rx_valid       = 1'b1;
      rx_data        = b;
      rx_frame_error = err;
      @(posedge CLOCK_50);
      #1;
      rx_valid       = 1'b0;
      rx_frame_error = 1'b0;
      repeat (GAP) @(posedge CLOCK_50);
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while ((wr_q.size() != 0 || tx_q.size() != 0 || state != 3'd0) && n < 3000) begin
         @(posedge CLOCK_50);
         n++;
      end
      @(negedge CLOCK_50);
      checkOutput({name, "_pending"}, wr_q.size() + tx_q.size(), 0);
      checkOutput({name, "_state"}, {29'd0, state}, 0);
   endtask

   always @(negedge CLOCK_50) begin
      checkOutput("busy_vs_state", {31'd0, busy}, {31'd0, state != 3'd0});
      if (wr_en) begin
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got write addr %0h data %0h, expected none", wr_addr, wr_data);
         end else begin
            wr_t e;
            e = wr_q.pop_front();
            checkOutput("wr_addr", {17'd0, wr_addr}, {17'd0, e.addr});
            checkOutput("wr_data", {29'd0, wr_data}, {29'd0, e.data});
            checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e.done});
         end
         if (frame_done) checkOutput("state_at_done", {29'd0, state}, 3);
         last_wr_cyc = cyc;
      end else begin
         checkOutput("frame_done_alone", {31'd0, frame_done}, 0);
      end
      if (tx_start) begin
         if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_tx: got tx_start with %0h, expected none", tx_data);
         end else begin
            checkOutput("tx_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
         end
         tx_cyc = cyc;
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (5) @(posedge CLOCK_50);
      #1 rst_n = 1'b1;
      @(negedge CLOCK_50);
      checkOutput("rst_state", {29'd0, state}, 0);
      checkOutput("rst_wr_en", {31'd0, wr_en}, 0);
      checkOutput("rst_wr_addr", {17'd0, wr_addr}, 0);
      checkOutput("rst_wr_data", {29'd0, wr_data}, 0);
      checkOutput("rst_tx_start", {31'd0, tx_start}, 0);
      checkOutput("rst_tx_data", {24'd0, tx_data}, 0);
      checkOutput("rst_busy", {31'd0, busy}, 0);
      checkOutput("rst_frame_done", {31'd0, frame_done}, 0);
      checkOutput("rst_err_count", {24'd0, err_count}, 0);

      // Good frame
      for (int i = 0; i < FP; i++) pushWrite(i, i, i == FP - 1);
      tx_q.push_back(8'h06);
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'h5A, 1'b0);
      for (int i = 0; i < FP; i++) applyStimulus(8'(i), 1'b0);
      waitDrain("good");
      checkOutput("good_err_count", {24'd0, err_count}, 0);

      // Header resync: stray byte, repeated first header byte, pixels with upper bits set
      for (int i = 0; i < FP; i++) pushWrite(i, 7, i == FP - 1);
      tx_q.push_back(8'h06);
      applyStimulus(8'h11, 1'b0);
      checkOutput("resync_ignore", {29'd0, state}, 0);
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'hA5, 1'b0);
      checkOutput("resync_hdr", {29'd0, state}, 1);
      applyStimulus(8'h5A, 1'b0);
      for (int i = 0; i < FP; i++) applyStimulus(8'hFF, 1'b0);
      waitDrain("resync");

      // Timeout after three pixels
      for (int i = 0; i < 3; i++) pushWrite(i, i, 1'b0);
      tx_q.push_back(8'h15);
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'h5A, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(8'(i), 1'b0);
      waitDrain("timeout");
      checkOutput("timeout_err_count", {24'd0, err_count}, 1);
      checkOutput("timeout_latency", tx_cyc - last_wr_cyc, TO + 1);

      // Next frame restarts at address 0
      for (int i = 0; i < FP; i++) pushWrite(i, i, i == FP - 1);
      tx_q.push_back(8'h06);
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'h5A, 1'b0);
      for (int i = 0; i < FP; i++) applyStimulus(8'hF8 + 8'(i), 1'b0);
      waitDrain("restart");
      checkOutput("restart_err_count", {24'd0, err_count}, 1);

      // Framing error colliding with a byte, reply held off by tx_busy
      pushWrite(0, 0, 1'b0);
      pushWrite(1, 1, 1'b0);
      tx_q.push_back(8'h15);
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'h5A, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h01, 1'b0);
      tx_busy = 1'b1;
      applyStimulus(8'h02, 1'b1);
      repeat (30) @(posedge CLOCK_50);
      #1;
      checkOutput("nak_held_state", {29'd0, state}, 3);
      checkOutput("nak_held_queue", tx_q.size(), 1);
      tx_busy  = 1'b0;
      drop_cyc = cyc;
      waitDrain("collision");
      checkOutput("collision_err_count", {24'd0, err_count}, 2);
      checkOutput("collision_tx_timing", tx_cyc, drop_cyc + 1);

      // Reset in the middle of a frame
      for (int i = 0; i < 4; i++) pushWrite(i, 3 - i, 1'b0);
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'h5A, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(8'(3 - i), 1'b0);
      checkOutput("midframe_state", {29'd0, state}, 2);
      @(posedge CLOCK_50);
      #3 rst_n = 1'b0;
      #2;
      checkOutput("async_rst_state", {29'd0, state}, 0);
      checkOutput("async_rst_busy", {31'd0, busy}, 0);
      checkOutput("async_rst_err_count", {24'd0, err_count}, 0);
      checkOutput("async_rst_tx_data", {24'd0, tx_data}, 0);
      checkOutput("async_rst_wr_addr", {17'd0, wr_addr}, 0);
      repeat (5) @(posedge CLOCK_50);
      #1 rst_n = 1'b1;
      repeat (TO + 100) @(posedge CLOCK_50);
      waitDrain("midreset");
      checkOutput("midreset_err_count", {24'd0, err_count}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
